// File: rtl/btn_pkg.sv
// Shared button indices, id-width helper and event type for the button event arbiter.
package btn_pkg;

  typedef enum logic [2:0] {
    BTN_U = 3'd0,
    BTN_D = 3'd1,
    BTN_L = 3'd2,
    BTN_R = 3'd3,
    BTN_C = 3'd4
  } btn_id_e;

  localparam int unsigned NBTN_DEFAULT = 5;

  // clog2 with a floor of 1 so a single-button build still has an id bit.
  function automatic int unsigned btn_idw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned IDW_DEFAULT = btn_idw(NBTN_DEFAULT);

  typedef struct packed {
    logic                   valid;
    logic [IDW_DEFAULT-1:0] id;
  } btn_evt_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stable-count debouncer, debounced level and rise pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    state_d = state_q;
    rise_o  = 1'b0;
    if (sync2_q != state_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        state_d = ~state_q;
        rise_o  = ~state_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = state_q;

endmodule

// File: rtl/btn_event_arbiter.sv
// Debounced button presses latched as pending flags and granted round-robin onto a valid/ready port.
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
module btn_event_arbiter
  import btn_pkg::*;
#(
  parameter  int unsigned Nbtn            = NBTN_DEFAULT,
  parameter  int unsigned DEBOUNCE_CYCLES = 16,
  parameter  int unsigned REPEAT_DELAY    = 64,
  parameter  int unsigned REPEAT_PERIOD   = 32,
  localparam int unsigned IDW             = btn_idw(Nbtn)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [Nbtn-1:0] btn,
  output logic [Nbtn-1:0] btn_state,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [IDW-1:0]  evt_id,
  output logic            evt_overrun
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD == 0 ||
      REPEAT_PERIOD > REPEAT_DELAY) begin : g_cfg_err
    $error("btn_event_arbiter: illegal debounce/repeat parameters");
  end

  logic [Nbtn-1:0] rise;
  logic [Nbtn-1:0] repeat_hit;

  for (genvar i = 0; i < Nbtn; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .btn_i  (btn[i]),
      .level_o(btn_state[i]),
      .rise_o (rise[i])
    );
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned HCW = $clog2(REPEAT_DELAY);

  logic [HCW-1:0] hold_q [Nbtn];
  logic [HCW-1:0] hold_d [Nbtn];

  // After the first repeat the counter reloads so the next hit is REPEAT_PERIOD away.
  always_comb begin
    repeat_hit = '0;
    for (int unsigned i = 0; i < Nbtn; i++) begin
      hold_d[i] = '0;
      if (btn_state[i]) begin
        if (hold_q[i] == HCW'(REPEAT_DELAY - 1)) begin
          repeat_hit[i] = 1'b1;
          hold_d[i]     = HCW'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Nbtn; i++) hold_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < Nbtn; i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  assign repeat_hit = '0;
`endif

  logic [Nbtn-1:0] pending_q, pending_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic            valid_q, valid_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            ovr_q, ovr_d;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    scan_sum;
  logic [IDW-1:0]  scan_idx;
  logic            load;
  logic [Nbtn-1:0] press, grant_mask;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < Nbtn; k++) begin
      scan_sum = {1'b0, rr_q} + (IDW + 1)'(k);
      if (scan_sum >= (IDW + 1)'(Nbtn)) scan_sum = scan_sum - (IDW + 1)'(Nbtn);
      scan_idx = scan_sum[IDW-1:0];
      if (!grant_found && pending_q[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // A press on the button being granted this cycle re-arms it instead of overrunning.
  always_comb begin
    load       = !valid_q || evt_ready;
    press      = rise | repeat_hit;
    grant_mask = '0;
    valid_d    = valid_q;
    id_d       = id_q;
    rr_d       = rr_q;
    if (load) begin
      valid_d = grant_found;
      if (grant_found) begin
        grant_mask = Nbtn'(1) << grant_idx;
        id_d       = grant_idx;
        rr_d       = (grant_idx == IDW'(Nbtn - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
    ovr_d     = |(press & pending_q & ~grant_mask);
    pending_d = (pending_q & ~grant_mask) | press;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      rr_q      <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      ovr_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      ovr_q     <= ovr_d;
    end
  end

  assign evt_valid   = valid_q;
  assign evt_id      = id_q;
  assign evt_overrun = ovr_q;

endmodule
